// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - start/key request and round-key stream of the AES key schedule.
interface aes_key_schedule_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         err;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  busy, err, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output busy, err, rk_valid, rk_data, rk_round, rk_last
  );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128/192/256 key expansion streaming round keys over valid/ready.
module aes_key_schedule #(
  parameter int SBOX_LANES = 4
) (
  input logic              clk,
  input logic              rst_n,
  aes_key_schedule_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] EXPAND = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (square-and-multiply), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]   state;
  logic         busy_q;
  logic         err_q;
  logic [1:0]   len_q;
  logic [255:0] key_q;
  logic [31:0]  win [8];
  logic [5:0]   idx;
  logic [2:0]   pos;
  logic [7:0]   rcon;
  logic [31:0]  acc [4];
  logic [2:0]   acc_cnt;
  logic [3:0]   out_round;
  logic         rk_valid_q;
  logic [127:0] rk_data_q;
  logic [3:0]   rk_round_q;
  logic         rk_last_q;

  logic [2:0]  nk_m1;
  logic [3:0]  nr;
  logic [5:0]  last_idx;
  logic        accept;
  logic        can_move;
  logic        acc_full;
  logic        stall;
  logic        move;
  logic        need_rot;
  logic        need_sub;
  logic [31:0] t_prev;
  logic [31:0] sub_in;
  logic [31:0] sub_word;
  logic        sub_done;
  logic [31:0] t_word;
  logic [31:0] new_word;
  logic        word_fire;

  always_comb begin
    nk_m1    = 3'd3;
    nr       = 4'd10;
    last_idx = 6'd43;
    case (len_q)
      2'b01:   begin nk_m1 = 3'd5; nr = 4'd12; last_idx = 6'd51; end
      2'b10:   begin nk_m1 = 3'd7; nr = 4'd14; last_idx = 6'd59; end
      default: begin nk_m1 = 3'd3; nr = 4'd10; last_idx = 6'd43; end
    endcase
  end

  assign accept   = (state == IDLE) && bus.start && (bus.key_len != 2'b11);
  assign can_move = !rk_valid_q || bus.rk_ready;
  assign acc_full = (acc_cnt == 3'd4);
  assign stall    = acc_full && !can_move;
  assign move     = acc_full && can_move;

  assign t_prev   = win[0];
  assign need_rot = (state == EXPAND) && (pos == 3'd0);
  assign need_sub = need_rot || ((state == EXPAND) && (len_q == 2'b10) && (pos == 3'd4));
  assign sub_in   = need_rot ? {t_prev[23:0], t_prev[31:24]} : t_prev;

  generate
    if (SBOX_LANES == 1) begin : g_lane1
      logic [1:0]  lane;
      logic [23:0] sub_part;
      logic [7:0]  lane_byte;
      logic [7:0]  sbox_out;

      always_comb begin
        lane_byte = sub_in[31:24];
        case (lane)
          2'd1:    lane_byte = sub_in[23:16];
          2'd2:    lane_byte = sub_in[15:8];
          2'd3:    lane_byte = sub_in[7:0];
          default: lane_byte = sub_in[31:24];
        endcase
      end

      assign sbox_out = sbox(lane_byte);
      assign sub_word = {sub_part, sbox_out};
      assign sub_done = (lane == 2'd3);

      // Lane wraps back to 0 on the cycle the finished word is emitted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane     <= 2'd0;
          sub_part <= 24'h0;
        end else if (!stall && need_sub) begin
          lane     <= lane + 2'd1;
          sub_part <= {sub_part[15:0], sbox_out};
        end
      end
    end else begin : g_lane4
      assign sub_word = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                         sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
      assign sub_done = 1'b1;
    end
  endgenerate

  assign t_word    = need_rot ? (sub_word ^ {rcon, 24'h0}) : (need_sub ? sub_word : t_prev);
  assign new_word  = (state == LOAD) ? key_q[255:224] : (win[nk_m1] ^ t_word);
  assign word_fire = !stall && ((state == LOAD) || ((state == EXPAND) && (!need_sub || sub_done)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      len_q  <= 2'b00;
      key_q  <= '0;
      idx    <= 6'd0;
      pos    <= 3'd0;
      rcon   <= 8'h01;
      for (int k = 0; k < 8; k++) win[k] <= 32'h0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.key_len == 2'b11) begin
            err_q <= 1'b1;
          end else if (accept) begin
            state  <= LOAD;
            busy_q <= 1'b1;
            len_q  <= bus.key_len;
            key_q  <= bus.key_in;
            idx    <= 6'd0;
            pos    <= 3'd0;
            rcon   <= 8'h01;
          end
        end
        LOAD: begin
          if (word_fire && idx == {3'd0, nk_m1}) state <= EXPAND;
        end
        EXPAND: begin
          if (word_fire && idx == last_idx) state <= DRAIN;
        end
        default: begin
          if (rk_valid_q && bus.rk_ready && rk_last_q) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase

      if (word_fire) begin
        win[0] <= new_word;
        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
        if (state == LOAD) key_q <= {key_q[223:0], 32'h0};
        idx <= idx + 6'd1;
        pos <= (pos == nk_m1) ? 3'd0 : pos + 3'd1;
        if (need_rot) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // A full accumulator empties into the output register on the same edge a new word lands in slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) acc[k] <= 32'h0;
      acc_cnt    <= 3'd0;
      out_round  <= 4'd0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= 4'd0;
      rk_last_q  <= 1'b0;
    end else begin
      if (accept)    out_round <= 4'd0;
      else if (move) out_round <= out_round + 4'd1;

      if (move) begin
        rk_valid_q <= 1'b1;
        rk_data_q  <= {acc[0], acc[1], acc[2], acc[3]};
        rk_round_q <= out_round;
        rk_last_q  <= (out_round == nr);
      end else if (rk_valid_q && bus.rk_ready) begin
        rk_valid_q <= 1'b0;
      end

      if (word_fire) begin
        if (move) begin
          acc[0]  <= new_word;
          acc_cnt <= 3'd1;
        end else begin
          acc[acc_cnt[1:0]] <= new_word;
          acc_cnt           <= acc_cnt + 3'd1;
        end
      end else if (move) begin
        acc_cnt <= 3'd0;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_round = rk_round_q;
  assign bus.rk_last  = rk_last_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule with 4-lane and 1-lane instances.
module tb_aes_key_schedule;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rk_ready = 1'b1;
  logic         sel;

  aes_key_schedule_if bus4();
  aes_key_schedule_if bus1();

  aes_key_schedule #(.SBOX_LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  aes_key_schedule #(.SBOX_LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus4.start    = start & ~sel;
  assign bus1.start    = start & sel;
  assign bus4.key_len  = key_len;
  assign bus1.key_len  = key_len;
  assign bus4.key_in   = key_in;
  assign bus1.key_in   = key_in;
  assign bus4.rk_ready = rk_ready;
  assign bus1.rk_ready = rk_ready;

  logic         m_busy, m_err, m_valid, m_last;
  logic [127:0] m_data;
  logic [3:0]   m_round;
  assign m_busy  = sel ? bus1.busy     : bus4.busy;
  assign m_err   = sel ? bus1.err      : bus4.err;
  assign m_valid = sel ? bus1.rk_valid : bus4.rk_valid;
  assign m_data  = sel ? bus1.rk_data  : bus4.rk_data;
  assign m_round = sel ? bus1.rk_round : bus4.rk_round;
  assign m_last  = sel ? bus1.rk_last  : bus4.rk_last;

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128_RL = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] K192_RL = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_RL = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] ALL     = {128{1'b1}};
  localparam logic [127:0] HI64    = {{64{1'b1}}, 64'h0};

  typedef struct {
    logic [3:0]   round;
    logic         last;
    logic [127:0] data;
    logic [127:0] mask;
    int           vcyc;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0 = 0;
  int hs_cnt = 0;
  int first_seen = 0;
  bit rand_ready = 1'b0;
  bit held = 1'b0;
  logic [127:0] h_data;
  logic [3:0]   h_round;
  logic         h_last;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drives rk_ready, pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    rk_ready = rand_ready ? ($urandom_range(99, 0) < 30) : 1'b1;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("valid held in stall", 128'(m_valid), 128'(1));
        check("data held in stall", m_data, h_data);
        check("round held in stall", 128'(m_round), 128'(h_round));
        check("last held in stall", 128'(m_last), 128'(h_last));
      end
      if (m_valid) begin
        if (!held) first_seen = cyc;
        if (rk_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected key: round %0d data %0h", m_round, m_data);
          end else begin
            e = exp_q.pop_front();
            check("rk_round", 128'(m_round), 128'(e.round));
            check("rk_last", 128'(m_last), 128'(e.last));
            if (e.mask != '0) check("rk_data", m_data & e.mask, e.data & e.mask);
            if (e.vcyc != 0) check("last key valid edge", 128'(first_seen - e0), 128'(e.vcyc));
          end
        end
      end
      held    = m_valid && !rk_ready;
      h_data  = m_data;
      h_round = m_round;
      h_last  = m_last;
    end
  end

  task automatic push_run(input int nr, input logic [127:0] r0, input logic [127:0] r1,
                          input logic [127:0] m1, input logic [127:0] rl, input int vl);
    exp_t e;
    for (int r = 0; r <= nr; r++) begin
      e.round = r[3:0];
      e.last  = (r == nr);
      e.data  = (r == 0) ? r0 : (r == 1) ? r1 : (r == nr) ? rl : '0;
      e.mask  = (r == 0 || r == nr) ? ALL : (r == 1) ? m1 : '0;
      e.vcyc  = (r == nr) ? vl : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] len, input logic [255:0] key);
    @(negedge clk);
    start   = 1'b1;
    key_len = len;
    key_in  = key;
    @(negedge clk);
    start  = 1'b0;
    e0     = cyc;
    key_in = ~key;
  endtask

  task automatic wait_done(input int budget, input int fall);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL run timeout: busy %0b pending %0d", m_busy, exp_q.size());
      exp_q.delete();
    end else if (fall != 0) begin
      check("busy fall edge", 128'(cyc - e0), 128'(fall));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, 128'(m_busy), 128'(0));
    check({tag, " err"}, 128'(m_err), 128'(0));
    check({tag, " rk_valid"}, 128'(m_valid), 128'(0));
    check({tag, " rk_data"}, m_data, 128'(0));
    check({tag, " rk_round"}, 128'(m_round), 128'(0));
    check({tag, " rk_last"}, 128'(m_last), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; key_len = 2'b00; key_in = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset lane1 busy", 128'(bus1.busy), 128'(0));
    check("reset lane1 rk_valid", 128'(bus1.rk_valid), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128, 4 lanes, with a stray start mid-run.
    push_run(10, K128, K128_R1, ALL, K128_RL, 45);
    issue(2'b00, {K128, 128'h0});
    repeat (10) @(negedge clk);
    start = 1'b1; key_len = 2'b10; key_in = {2{K128_RL}};
    @(negedge clk);
    start = 1'b0;
    wait_done(500, 46);

    // AES-192, 4 lanes, start raised on the final handshake cycle.
    push_run(12, K192[191:64], {K192[63:0], 64'h0}, HI64, K192_RL, 53);
    issue(2'b01, {K192, 64'h0});
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (m_valid && m_last) begin
        start = 1'b1; key_len = 2'b00;
        @(negedge clk);
        start = 1'b0;
        check("busy after start on final handshake", 128'(m_busy), 128'(0));
        break;
      end
    end
    wait_done(500, 0);
    repeat (10) @(negedge clk);
    check("no run from ignored start", 128'(m_busy), 128'(0));

    // AES-256, 4 lanes.
    push_run(14, K256[255:128], K256[127:0], ALL, K256_RL, 61);
    issue(2'b10, K256);
    wait_done(500, 62);

    // Illegal key length.
    @(negedge clk);
    start = 1'b1; key_len = 2'b11;
    @(negedge clk);
    start = 1'b0;
    check("err pulse", 128'(m_err), 128'(1));
    check("busy on illegal start", 128'(m_busy), 128'(0));
    @(negedge clk);
    check("err one cycle", 128'(m_err), 128'(0));
    check("busy after illegal start", 128'(m_busy), 128'(0));

    // AES-256 under random backpressure.
    rand_ready = 1'b1;
    hs_cnt = 0;
    push_run(14, K256[255:128], K256[127:0], ALL, K256_RL, 0);
    issue(2'b10, K256);
    wait_done(3000, 0);
    rand_ready = 1'b0;
    @(negedge clk);
    check("handshakes under backpressure", 128'(hs_cnt), 128'(15));

    // Reset in the middle of an AES-128 run, then a clean rerun.
    push_run(10, K128, K128_R1, ALL, K128_RL, 45);
    issue(2'b00, {K128, 128'h0});
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-run reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no key after abort", 128'(m_valid), 128'(0));
    check("idle after abort", 128'(m_busy), 128'(0));
    push_run(10, K128, K128_R1, ALL, K128_RL, 45);
    issue(2'b00, {K128, 128'h0});
    wait_done(500, 46);

    // Single S-box lane: each SubWord word costs three extra cycles.
    sel = 1'b1;
    @(negedge clk);
    push_run(10, K128, K128_R1, ALL, K128_RL, 75);
    issue(2'b00, {K128, 128'h0});
    wait_done(800, 0);
    push_run(12, K192[191:64], {K192[63:0], 64'h0}, HI64, K192_RL, 77);
    issue(2'b01, {K192, 64'h0});
    wait_done(800, 0);
    push_run(14, K256[255:128], K256[127:0], ALL, K256_RL, 100);
    issue(2'b10, K256);
    wait_done(800, 101);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
